// File: rtl/csr_master.sv
// csr_master: sys_clk-domain initiator for the CSR strobe interface.
// A request accepted on req_valid/req_ready becomes an address strobe pulse,
// a settle gap, and (writes only) a data strobe pulse plus settle gap. The
// transaction then completes with a single-cycle rsp_valid carrying csr_data.
// Each strobe is a registered level held PULSE_CYCLES cycles. The CSR block
// synchronises it and acts on its falling edge, so SETTLE_CYCLES must cover
// that block's sync, edge-detect and register-update path.
// Optional build macro CSR_MASTER_ECHO_CHK_EN: compares the CSR address echo
// against the issued address and reports a mismatch on rsp_err.
module csr_master #(
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        m_csr_addr_valid,
  output logic [2:0]  m_csr_addr,
  output logic        m_csr_data_valid,
  output logic [31:0] m_csr_data,
  input  logic [2:0]  csr_addr,
  input  logic [31:0] csr_data
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] ADDR_HI     = 3'd1;
  localparam logic [2:0] ADDR_SETTLE = 3'd2;
  localparam logic [2:0] DATA_HI     = 3'd3;
  localparam logic [2:0] DATA_SETTLE = 3'd4;
  localparam logic [2:0] RESP        = 3'd5;

  localparam int MAX_CYCLES = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  // The counter is loaded with N-1 on state entry, so a state lasts N cycles.
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  if (PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("csr_master: PULSE_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("csr_master: SETTLE_CYCLES must be >= 1");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             cnt_done;
  logic             is_write;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign cnt_done  = (cnt == '0);
  // rw bit of the issued address is 0 for a write.
  assign is_write  = ~m_csr_addr[0];

  // Sequencer: strobe timing, issued address/data and response capture.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      m_csr_addr_valid <= 1'b0;
      m_csr_addr       <= 3'b001;
      m_csr_data_valid <= 1'b0;
      m_csr_data       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state            <= ADDR_HI;
            cnt              <= PULSE_LD;
            m_csr_addr_valid <= 1'b1;
            m_csr_addr       <= {req_addr, ~req_write};
            if (req_write) m_csr_data <= req_wdata;
          end
        end
        ADDR_HI: begin
          if (cnt_done) begin
            state            <= ADDR_SETTLE;
            cnt              <= SETTLE_LD;
            m_csr_addr_valid <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ADDR_SETTLE: begin
          if (cnt_done) begin
            if (is_write) begin
              state            <= DATA_HI;
              cnt              <= PULSE_LD;
              m_csr_data_valid <= 1'b1;
            end else begin
              state     <= RESP;
              cnt       <= '0;
              rsp_valid <= 1'b1;
              rsp_rdata <= csr_data;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DATA_HI: begin
          if (cnt_done) begin
            state            <= DATA_SETTLE;
            cnt              <= SETTLE_LD;
            m_csr_data_valid <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DATA_SETTLE: begin
          if (cnt_done) begin
            state     <= RESP;
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= csr_data;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state            <= IDLE;
          cnt              <= '0;
          m_csr_addr_valid <= 1'b0;
          m_csr_data_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CSR_MASTER_ECHO_CHK_EN
  logic echo_err;

  // Echo mismatch flag: cleared on acceptance, set when the echo disagrees at the end of the address settle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      echo_err <= 1'b0;
    end else if (accept) begin
      echo_err <= 1'b0;
    end else if ((state == ADDR_SETTLE) && cnt_done && (csr_addr != m_csr_addr)) begin
      echo_err <= 1'b1;
    end
  end

  assign rsp_err = echo_err;
`else
  // The address echo is not consumed when the echo check is compiled out.
  logic unused_csr_addr;
  assign unused_csr_addr = ^csr_addr;
  assign rsp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_csr_master.sv
// tb_csr_master: self-checking bench for csr_master with a behavioural CSR
// block partner (2-flop strobe sync, falling-edge action, 4 x 32-bit regs).
// Expected values come from a register-array model and latency formulas.
module tb_csr_master;

  localparam int P = 4;
  localparam int S = 4;
`ifdef CSR_MASTER_ECHO_CHK_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        m_csr_addr_valid;
  logic [2:0]  m_csr_addr;
  logic        m_csr_data_valid;
  logic [31:0] m_csr_data;
  logic [2:0]  csr_echo;
  logic [31:0] slv_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  csr_master #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_csr_addr_valid(m_csr_addr_valid), .m_csr_addr(m_csr_addr),
    .m_csr_data_valid(m_csr_data_valid), .m_csr_data(m_csr_data),
    .csr_addr(csr_echo), .csr_data(slv_rdata)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- CSR block partner ----------------
  logic        a1, a2, a3, d1, d2, d3;
  logic [2:0]  slv_addr;
  logic [31:0] slv_regs [4];
  logic        force_echo;

  assign slv_rdata = slv_regs[slv_addr[2:1]];
  assign csr_echo  = force_echo ? 3'b111 : slv_addr;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {a1, a2, a3, d1, d2, d3} <= '0;
      slv_addr <= 3'b001;
      for (int i = 0; i < 4; i++) slv_regs[i] <= '0;
    end else begin
      a1 <= m_csr_addr_valid; a2 <= a1; a3 <= a2;
      d1 <= m_csr_data_valid; d2 <= d1; d3 <= d2;
      if (a3 && !a2) slv_addr <= m_csr_addr;
      if (d3 && !d2 && !slv_addr[0]) slv_regs[slv_addr[2:1]] <= m_csr_data;
    end
  end

  // ---------------- monitors ----------------
  int          cyc = 0, n_acc = 0, acc_cyc = 0;
  int          n_rsp = 0, rsp_cyc = 0;
  int          n_addr_hi = 0, n_data_hi = 0, n_addr_fall = 0, n_data_fall = 0, n_both = 0;
  logic        prev_av = 1'b0, prev_dv = 1'b0;
  logic [31:0] rsp_rdata_q = '0;
  logic        rsp_err_q = 1'b0;

  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    if (sys_rst_n && req_valid && req_ready) begin
      n_acc   = n_acc + 1;
      acc_cyc = cyc;
    end
  end

  always @(negedge sys_clk) begin
    if (m_csr_addr_valid) n_addr_hi = n_addr_hi + 1;
    if (m_csr_data_valid) n_data_hi = n_data_hi + 1;
    if (prev_av && !m_csr_addr_valid) n_addr_fall = n_addr_fall + 1;
    if (prev_dv && !m_csr_data_valid) n_data_fall = n_data_fall + 1;
    if (m_csr_addr_valid && m_csr_data_valid) n_both = n_both + 1;
    prev_av = m_csr_addr_valid;
    prev_dv = m_csr_data_valid;
    if (rsp_valid) begin
      n_rsp       = n_rsp + 1;
      rsp_cyc     = cyc;
      rsp_rdata_q = rsp_rdata;
      rsp_err_q   = rsp_err;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] model_regs [4];
  logic [31:0] last_wd;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    last_wd = '0;
  endtask

  // Issue one request and wait for its response; called at negedge+1.
  task automatic do_txn(input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                        output int lat, output int ahi, output int dhi, output int afl,
                        output int dfl, output int bth, output logic [31:0] rd,
                        output logic er, output bit to);
    int a0, r0, h0, e0, f0, g0, b0, t;
    to = 1'b0;
    a0 = n_acc; r0 = n_rsp; h0 = n_addr_hi; e0 = n_data_hi;
    f0 = n_addr_fall; g0 = n_data_fall; b0 = n_both;
    req_write = wr; req_addr = idx; req_wdata = wd; req_valid = 1'b1;
    t = 0;
    while (n_acc == a0 && t < 100) begin @(negedge sys_clk); #1; t++; end
    req_valid = 1'b0;
    if (n_acc == a0) to = 1'b1;
    t = 0;
    while (n_rsp == r0 && t < 100) begin @(negedge sys_clk); #1; t++; end
    if (n_rsp == r0) to = 1'b1;
    lat = rsp_cyc - acc_cyc;
    ahi = n_addr_hi - h0;   dhi = n_data_hi - e0;
    afl = n_addr_fall - f0; dfl = n_data_fall - g0;
    bth = n_both - b0;
    rd = rsp_rdata_q; er = rsp_err_q;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int r0, s0;
    sys_rst_n = 1'b0; req_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    n_tests++; if ({m_csr_addr_valid, m_csr_data_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b%b want 00", m_csr_addr_valid, m_csr_data_valid); end
    n_tests++; if (m_csr_addr !== 3'b001) begin n_fail++; $display("FAIL rst_m_csr_addr: got %b want 001", m_csr_addr); end
    n_tests++; if (m_csr_data !== 32'h0) begin n_fail++; $display("FAIL rst_m_csr_data: got %h want 0", m_csr_data); end
    @(negedge sys_clk); sys_rst_n = 1'b1; #1;
    model_reset();
    r0 = n_rsp; s0 = n_addr_hi + n_data_hi;
    repeat (20) @(negedge sys_clk);
    #1;
    n_tests++; if (n_rsp !== r0) begin n_fail++; $display("FAIL idle_rsp_count: got %0d want %0d", n_rsp, r0); end
    n_tests++; if (n_addr_hi + n_data_hi !== s0) begin n_fail++; $display("FAIL idle_strobe_cycles: got %0d want %0d", n_addr_hi + n_data_hi, s0); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    n_tests++; if (m_csr_addr !== 3'b001) begin n_fail++; $display("FAIL idle_m_csr_addr: got %b want 001", m_csr_addr); end
  endtask

  task automatic test_write_led();
    int lat, ahi, dhi, afl, dfl, bth; logic [31:0] rd; logic er; bit to;
    do_txn(1'b1, 2'd0, 32'h0000_000A, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
    model_regs[0] = 32'h0000_000A; last_wd = 32'h0000_000A;
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL led_timeout: got %b want 0", to); end
    n_tests++; if (lat !== 2 * (P + S)) begin n_fail++; $display("FAIL led_latency: got %0d want %0d", lat, 2 * (P + S)); end
    n_tests++; if (ahi !== P) begin n_fail++; $display("FAIL led_addr_hi: got %0d want %0d", ahi, P); end
    n_tests++; if (dhi !== P) begin n_fail++; $display("FAIL led_data_hi: got %0d want %0d", dhi, P); end
    n_tests++; if (bth !== 0) begin n_fail++; $display("FAIL led_both_high: got %0d want 0", bth); end
    n_tests++; if (slv_regs[0][3:0] !== 4'hA) begin n_fail++; $display("FAIL led_value: got %h want a", slv_regs[0][3:0]); end
    n_tests++; if (rd !== 32'h0000_000A) begin n_fail++; $display("FAIL led_rsp_rdata: got %h want 0000000a", rd); end
    n_tests++; if (m_csr_addr !== 3'b000) begin n_fail++; $display("FAIL led_m_csr_addr: got %b want 000", m_csr_addr); end
  endtask

  task automatic test_write_read();
    int lat, ahi, dhi, afl, dfl, bth; logic [31:0] rd; logic er; bit to;
    do_txn(1'b1, 2'd2, 32'hDEAD_BEEF, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
    model_regs[2] = 32'hDEAD_BEEF; last_wd = 32'hDEAD_BEEF;
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL wr2_timeout: got %b want 0", to); end
    do_txn(1'b0, 2'd2, 32'h1234_5678, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rd2_timeout: got %b want 0", to); end
    n_tests++; if (lat !== P + S) begin n_fail++; $display("FAIL rd2_latency: got %0d want %0d", lat, P + S); end
    n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd2_rdata: got %h want deadbeef", rd); end
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd2_err: got %b want 0", er); end
    n_tests++; if (dhi !== 0 || dfl !== 0) begin n_fail++; $display("FAIL rd2_no_data_strobe: got hi=%0d falls=%0d want 0/0", dhi, dfl); end
    n_tests++; if (m_csr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd2_data_hold: got %h want deadbeef", m_csr_data); end
  endtask

  task automatic test_busy_hold();
    int a0, r0, f0, g0, acc1, rsp1, t;
    logic [31:0] wd1;
    wd1 = $urandom;
    a0 = n_acc; r0 = n_rsp; f0 = n_addr_fall; g0 = n_data_fall;
    req_write = 1'b1; req_addr = 2'd3; req_wdata = wd1; req_valid = 1'b1;
    t = 0;
    while (n_acc == a0 && t < 100) begin @(negedge sys_clk); #1; t++; end
    acc1 = acc_cyc;
    t = 0;
    while (n_rsp == r0 && t < 100) begin
      req_write = 1'($urandom); req_addr = 2'($urandom); req_wdata = $urandom;
      @(negedge sys_clk); #1; t++;
    end
    rsp1 = rsp_cyc;
    n_tests++; if (n_acc !== a0 + 1) begin n_fail++; $display("FAIL busy_accepts: got %0d want %0d", n_acc - a0, 1); end
    n_tests++; if (n_rsp !== r0 + 1) begin n_fail++; $display("FAIL busy_rsp_count: got %0d want 1", n_rsp - r0); end
    n_tests++; if (rsp1 - acc1 !== 2 * (P + S)) begin n_fail++; $display("FAIL busy_latency: got %0d want %0d", rsp1 - acc1, 2 * (P + S)); end
    n_tests++; if (rsp_rdata_q !== wd1) begin n_fail++; $display("FAIL busy_rdata: got %h want %h", rsp_rdata_q, wd1); end
    n_tests++; if (m_csr_data !== wd1) begin n_fail++; $display("FAIL busy_m_csr_data: got %h want %h", m_csr_data, wd1); end
    n_tests++; if (n_addr_fall - f0 !== 1 || n_data_fall - g0 !== 1) begin n_fail++; $display("FAIL busy_strobe_falls: got %0d/%0d want 1/1", n_addr_fall - f0, n_data_fall - g0); end
    model_regs[3] = wd1; last_wd = wd1;
    // Second request: read index 3, kept valid straight through.
    a0 = n_acc; r0 = n_rsp;
    req_write = 1'b0; req_addr = 2'd3;
    t = 0;
    while (n_acc == a0 && t < 100) begin @(negedge sys_clk); #1; t++; end
    req_valid = 1'b0;
    n_tests++; if (acc_cyc - rsp1 !== 2) begin n_fail++; $display("FAIL busy_next_accept_gap: got %0d want 2", acc_cyc - rsp1); end
    t = 0;
    while (n_rsp == r0 && t < 100) begin @(negedge sys_clk); #1; t++; end
    n_tests++; if (rsp_cyc - acc_cyc !== P + S) begin n_fail++; $display("FAIL busy_read_latency: got %0d want %0d", rsp_cyc - acc_cyc, P + S); end
    n_tests++; if (rsp_rdata_q !== wd1) begin n_fail++; $display("FAIL busy_read_rdata: got %h want %h", rsp_rdata_q, wd1); end
  endtask

  task automatic test_random();
    int lat, ahi, dhi, afl, dfl, bth; logic [31:0] rd, wd, exp_rd; logic er; bit to, wr; logic [1:0] idx;
    for (int k = 0; k < 16; k++) begin
      wr = 1'($urandom); idx = 2'($urandom); wd = $urandom;
      exp_rd = wr ? wd : model_regs[idx];
      do_txn(wr, idx, wd, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
      if (wr) begin model_regs[idx] = wd; last_wd = wd; end
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: got %b want 0", k, to); end
      n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", k, rd, exp_rd); end
      n_tests++; if (lat !== (wr ? 2 * (P + S) : P + S)) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, wr ? 2 * (P + S) : P + S); end
      n_tests++; if (ahi !== P || afl !== 1) begin n_fail++; $display("FAIL rnd%0d_addr_strobe: got hi=%0d falls=%0d want %0d/1", k, ahi, afl, P); end
      n_tests++; if (dhi !== (wr ? P : 0) || dfl !== (wr ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_data_strobe: got hi=%0d falls=%0d want %0d/%0d", k, dhi, dfl, wr ? P : 0, wr ? 1 : 0); end
      n_tests++; if (bth !== 0) begin n_fail++; $display("FAIL rnd%0d_both_high: got %0d want 0", k, bth); end
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_err: got %b want 0", k, er); end
      n_tests++; if (m_csr_addr !== {idx, ~wr}) begin n_fail++; $display("FAIL rnd%0d_m_csr_addr: got %b want %b", k, m_csr_addr, {idx, ~wr}); end
      n_tests++; if (m_csr_data !== last_wd) begin n_fail++; $display("FAIL rnd%0d_m_csr_data: got %h want %h", k, m_csr_data, last_wd); end
    end
  endtask

  task automatic test_echo();
    int lat, ahi, dhi, afl, dfl, bth; logic [31:0] rd, wd; logic er; bit to;
    force_echo = 1'b1;
    do_txn(1'b0, 2'd0, 32'h0, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
    force_echo = 1'b0;
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL echo_rd_timeout: got %b want 0", to); end
    n_tests++; if (er !== ECHO_EN) begin n_fail++; $display("FAIL echo_rd_err: got %b want %b", er, ECHO_EN); end
    n_tests++; if (rd !== model_regs[0]) begin n_fail++; $display("FAIL echo_rd_rdata: got %h want %h", rd, model_regs[0]); end
    do_txn(1'b0, 2'd0, 32'h0, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
    n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL echo_clean_err: got %b want 0", er); end
    wd = $urandom;
    force_echo = 1'b1;
    do_txn(1'b1, 2'd2, wd, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
    force_echo = 1'b0;
    model_regs[2] = wd; last_wd = wd;
    n_tests++; if (er !== ECHO_EN) begin n_fail++; $display("FAIL echo_wr_err: got %b want %b", er, ECHO_EN); end
    n_tests++; if (dfl !== 1 || rd !== wd) begin n_fail++; $display("FAIL echo_wr_data_phase: got falls=%0d rdata=%h want 1/%h", dfl, rd, wd); end
  endtask

  task automatic test_mid_reset();
    int lat, ahi, dhi, afl, dfl, bth, a0, r0, t; logic [31:0] rd; logic er; bit to;
    a0 = n_acc; r0 = n_rsp;
    req_write = 1'b1; req_addr = 2'd1; req_wdata = $urandom | 32'h1; req_valid = 1'b1;
    t = 0;
    while (m_csr_data_valid !== 1'b1 && t < 100) begin
      @(negedge sys_clk); #1; t++;
      if (n_acc != a0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    n_tests++; if (m_csr_data_valid !== 1'b1) begin n_fail++; $display("FAIL mid_reach_data_hi: got %b want 1", m_csr_data_valid); end
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    model_reset();
    n_tests++; if ({m_csr_addr_valid, m_csr_data_valid} !== 2'b00) begin n_fail++; $display("FAIL mid_strobes: got %b%b want 00", m_csr_addr_valid, m_csr_data_valid); end
    n_tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl: got ready=%b vld=%b err=%b want 1/0/0", req_ready, rsp_valid, rsp_err); end
    n_tests++; if (m_csr_addr !== 3'b001 || m_csr_data !== 32'h0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_data: got addr=%b data=%h rdata=%h want 001/0/0", m_csr_addr, m_csr_data, rsp_rdata); end
    @(negedge sys_clk); sys_rst_n = 1'b1; #1;
    n_tests++; if (n_rsp !== r0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d want %0d", n_rsp, r0); end
    do_txn(1'b0, 2'd1, 32'h0, lat, ahi, dhi, afl, dfl, bth, rd, er, to);
    n_tests++; if (to !== 1'b0 || rd !== model_regs[1]) begin n_fail++; $display("FAIL mid_idx1_unchanged: got to=%b rdata=%h want 0/%h", to, rd, model_regs[1]); end
  endtask

  initial begin
    sys_rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; force_echo = 1'b0;
    model_reset();
    test_reset();
    test_write_led();
    test_write_read();
    test_busy_hold();
    test_random();
    test_echo();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_master.md
Name: csr_master

Overview:
- sys_clk-domain initiator that drives the CSR access interface (address strobe, address/rw, data strobe, data) and reads back the CSR address echo and read data.
- Turns a simple request/response handshake into correctly timed strobe sequences. Each strobe is a level that the CSR block edge-detects on its falling edge after a 2-flop synchroniser.
- Used for on-chip bring-up sequencing and for loopback testing of the CSR block without a JTAG probe.

Parameters:
- PULSE_CYCLES, 4, sys_clk cycles each strobe is held high; legal range >= 1 (elaboration error otherwise).
- SETTLE_CYCLES, 4, sys_clk cycles waited after each strobe falls before advancing; legal range >= 4 so the CSR block's sync, edge detect and register update complete (elaboration error if < 1; values 1-3 allowed but unsupported).

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master idle, request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  2  CSR index 0-3
- req_wdata  in  32  write data
- rsp_valid  out  1  single-cycle response pulse
- rsp_rdata  out  32  read data (write: csr_data sampled at completion)
- rsp_err  out  1  address echo mismatch (see Optional Feature)
- m_csr_addr_valid  out  1  address strobe
- m_csr_addr  out  3  {index[1:0], rw}, rw: 0 = WR, 1 = RD
- m_csr_data_valid  out  1  data strobe
- m_csr_data  out  32  data word
- csr_addr  in  3  address/rw echo from CSR block
- csr_data  in  32  selected register value from CSR block

Behaviour:
- Reset values:
  - state IDLE, counter 0
  - req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0
  - m_csr_addr_valid 0, m_csr_data_valid 0
  - m_csr_addr 3'b001 (index 0, RD; matches the CSR block's reset), m_csr_data 0
- States:
  - IDLE -> ADDR_HI -> ADDR_SETTLE -> (write: DATA_HI -> DATA_SETTLE ->) RESP -> IDLE.
- req_ready = (state == IDLE), combinational.
- Acceptance at edge E0:
  - register m_csr_addr = {req_addr, ~req_write} and m_csr_data = req_wdata (write) or hold the previous value (read).
  - Both stay stable until the next acceptance.
- ADDR_HI: m_csr_addr_valid = 1 for exactly PULSE_CYCLES cycles.
- ADDR_SETTLE: strobe low for SETTLE_CYCLES cycles.
- DATA_HI / DATA_SETTLE: same pattern on m_csr_data_valid. Write only; reads issue no data strobe.
- RESP: rsp_valid = 1 for one cycle. rsp_rdata is loaded from csr_data on the edge entering RESP and held until the next RESP.
- Latency, acceptance edge to RESP entry:
  - read = P+S cycles (8 with defaults)
  - write = 2P+2S cycles (16 with defaults)
  - req_ready returns 1 the cycle after RESP.
- Strobes are registered outputs. Exactly one falling edge per strobe per transaction. Never both strobes high together.
- req_valid while busy: ignored; no queueing; request fields not sampled.
- Back-to-back requests: the next acceptance can occur the first IDLE cycle after RESP. No gap is required beyond that.
- Counter width $clog2(max(P,S)+1), reloaded on every state entry, no wrap.
- Reset mid-transaction: immediate return to reset values; a strobe dropped by reset is not retried.
  - The CSR block shares sys_rst_n and is reset together with the master.

Optional Feature:
- Macro CSR_MASTER_ECHO_CHK_EN.
- Defined:
  - On the edge leaving ADDR_SETTLE, compare csr_addr to m_csr_addr.
  - On mismatch, set a sticky-per-transaction flag, presented as rsp_err with rsp_valid and cleared on the next acceptance.
  - A write with mismatch still issues its data phase.
- Undefined: rsp_err tied to 0; no compare logic.

Test Plan:
- Reset, then idle 20 cycles -> req_ready=1, strobes 0, m_csr_addr=3'b001, rsp_valid never 1.
- Write index 0, data 0x0000000A, with the CSR block as DUT partner -> addr strobe high 4 cycles, data strobe high 4 cycles; rsp_valid 16 cycles after accept; CSR led output = 4'hA.
- Write index 2 = 0xDEADBEEF, then read index 2 -> read rsp_valid 8 cycles after its accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Hold req_valid high with changing fields during a write -> only the first request executed; second accepted the cycle after RESP; no extra strobe edges.
- Assert sys_rst_n low during DATA_HI of a write to index 1 -> all outputs at reset values next cycle; CSR index 1 unchanged at 0.
- CSR_MASTER_ECHO_CHK_EN defined, csr_addr forced to 3'b111 during a read of index 0 -> rsp_err=1 with rsp_valid; next clean read gives rsp_err=0.
